// File: rtl/oser4_word_feeder.sv
// Feeder for a 4:1 output serializer (OSER4 class).
// Accepts parallel words on a valid/ready stream, slices each into 4-bit
// nibbles (nibble 0 first), and drives the serializer tristate controls with
// a programmable lead/trail drive window around each burst.
//
// Ports:
//   clk          parallel clock (serializer PCLK), rising edge
//   rst          synchronous active-high reset
//   s_data       word to serialize; s_data[3:0] goes out first
//   s_last       final word of a burst
//   s_valid      word present
//   s_ready      word accepted on edge where s_valid & s_ready (combinational)
//   d            nibble to serializer D3..D0 (registered)
//   tx           serializer TX1..TX0; 2'b11 tristate, 2'b00 driven (registered)
//   busy         high outside IDLE (registered)
//   underrun_cnt saturating count of bursts ended by underrun (registered)
module oser4_word_feeder #(
  parameter int unsigned WORD_W   = 16,
  parameter logic [3:0]  IDLE_PAT = 4'b0000,
  parameter int unsigned TX_LEAD  = 1,
  parameter int unsigned TX_TRAIL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_last,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [3:0]        d,
  output logic [1:0]        tx,
  output logic              busy,
  output logic [7:0]        underrun_cnt
);

  localparam int unsigned N     = WORD_W / 4;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNT_W = 4;

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] LEAD_INIT  = CNT_W'(TX_LEAD);
  localparam logic [CNT_W-1:0] TRAIL_INIT = CNT_W'(TX_TRAIL);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAD,
    ST_DATA,
    ST_TRAIL
  } state_t;

  state_t              state_q, state_nxt;
  logic [IDX_W-1:0]    idx_q, idx_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;
  logic [WORD_W-1:0]   word_q, word_nxt;
  logic                last_q, last_nxt;
  logic [3:0]          d_q, d_nxt;
  logic [1:0]          tx_q, tx_nxt;
  logic                busy_q, busy_nxt;
  logic [7:0]          ucnt_q, ucnt_nxt;
  logic                accept;

  // Ready depends only on state/index so upstream never sees a valid->ready path.
  assign s_ready = !rst && ((state_q == ST_IDLE) ||
                            ((state_q == ST_DATA) && (idx_q == IDX_LAST) && !last_q));
  assign accept  = s_valid && s_ready;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      d_q     <= IDLE_PAT;
      tx_q    <= 2'b11;
      busy_q  <= 1'b0;
      ucnt_q  <= '0;
    end else begin
      state_q <= state_nxt;
      idx_q   <= idx_nxt;
      cnt_q   <= cnt_nxt;
      word_q  <= word_nxt;
      last_q  <= last_nxt;
      d_q     <= d_nxt;
      tx_q    <= tx_nxt;
      busy_q  <= busy_nxt;
      ucnt_q  <= ucnt_nxt;
    end
  end

  // Next-state logic; outputs are decoded from the next state so the
  // registered d/tx line up with the state they describe.
  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    cnt_nxt   = cnt_q;
    word_nxt  = word_q;
    last_nxt  = last_q;
    ucnt_nxt  = ucnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          word_nxt = s_data;
          last_nxt = s_last;
          idx_nxt  = '0;
          if (TX_LEAD == 0) begin
            state_nxt = ST_DATA;
          end else begin
            state_nxt = ST_LEAD;
            cnt_nxt   = LEAD_INIT;
          end
        end
      end

      ST_LEAD: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_nxt = ST_DATA;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (idx_q == IDX_LAST) begin
          if (accept) begin
            // Seamless continuation: next word's nibble 0 follows immediately.
            word_nxt = s_data;
            last_nxt = s_last;
            idx_nxt  = '0;
          end else begin
            // Either a real last word or an underrun; both close the burst.
            if (!last_q && (ucnt_q != 8'hFF)) begin
              ucnt_nxt = ucnt_q + 8'd1;
            end
            idx_nxt = '0;
            if (TX_TRAIL == 0) begin
              state_nxt = ST_IDLE;
            end else begin
              state_nxt = ST_TRAIL;
              cnt_nxt   = TRAIL_INIT;
            end
          end
        end else begin
          idx_nxt = idx_q + IDX_W'(1);
        end
      end

      ST_TRAIL: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    tx_nxt   = (state_nxt == ST_IDLE) ? 2'b11 : 2'b00;
    busy_nxt = (state_nxt != ST_IDLE);
    d_nxt    = (state_nxt == ST_DATA) ? 4'(word_nxt >> {idx_nxt, 2'b00}) : IDLE_PAT;
  end

  assign d            = d_q;
  assign tx           = tx_q;
  assign busy         = busy_q;
  assign underrun_cnt = ucnt_q;

endmodule
